// File: rtl/prog_clock_divider_pkg.sv
// Shared constants for the programmable clock-enable divider.
package prog_clock_divider_pkg;

  localparam int unsigned CNT_W_DEF       = 25;
  localparam int unsigned DEFAULT_DIV_DEF = 25000000;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/prog_clock_divider_if.sv
// Control/status bundle for prog_clock_divider: run enable, divisor load, mode and outputs.
interface prog_clock_divider_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 25
);
  logic                    en;
  logic [NUM_CH*CNT_W-1:0] div_i;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       mode_sq;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       clkout;

  modport master (
    output en, div_i, div_load, mode_sq,
    input  tick_o, clkout
  );

  modport slave (
    input  en, div_i, div_load, mode_sq,
    output tick_o, clkout
  );
endinterface

// File: rtl/prog_clock_divider_step_edge_detect.sv
// Two-flop synchroniser for an asynchronous push-button plus a one-cycle rising-edge pulse.
module prog_clock_divider_step_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  // [0],[1] synchronise; [2] holds the previous synchronised level.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d  = {sync_q[1:0], async_i};
    pulse_o = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock-enable generator (tick strobe + square/pulse clkout).
// Optional manual stepping when SINGLE_STEP_EN is defined.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic clkin,
  input  logic rst,
`ifdef SINGLE_STEP_EN
  input  logic step_mode,
  input  logic step_i,
`endif
  prog_clock_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RstDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RstCnt = (DEFAULT_DIV <= 1) ? '0 : CNT_W'(DEFAULT_DIV - 1);

  logic run;
  logic step_tick;

`ifdef SINGLE_STEP_EN
  logic step_pulse;

  prog_clock_divider_step_edge_detect u_step (
    .clk_i   (clkin),
    .rst_i   (rst),
    .async_i (step_i),
    .pulse_o (step_pulse)
  );

  assign run       = bus.en & ~step_mode;
  assign step_tick = step_mode & step_pulse;
`else
  assign run       = bus.en;
  assign step_tick = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_new;
    logic [CNT_W-1:0] d_eff;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    assign div_new = bus.div_i[c*CNT_W +: CNT_W];

    always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      clk_d  = clk_q;
      d_eff  = (div_q == '0) ? One : div_q;
      // A load wins over run and over a coincident terminal count.
      if (bus.div_load[c]) begin
        div_d = div_new;
        cnt_d = (div_new == '0) ? '0 : div_new - One;
        clk_d = 1'b0;
      end else begin
        if (run) begin
          if (cnt_q == '0) begin
            tick_d = 1'b1;
            cnt_d  = d_eff - One;
          end else begin
            cnt_d = cnt_q - One;
          end
        end else if (step_tick) begin
          tick_d = 1'b1;
        end
        case (bus.mode_sq[c])
          MODE_SQUARE: clk_d = clk_q ^ tick_d;
          MODE_PULSE:  clk_d = tick_d;
          default:     clk_d = clk_q;
        endcase
      end
    end

    always_ff @(posedge clkin) begin
      if (rst) begin
        div_q  <= RstDiv;
        cnt_q  <= RstCnt;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        div_q  <= div_d;
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
        clk_q  <= clk_d;
      end
    end

    assign bus.tick_o[c] = tick_q;
    assign bus.clkout[c] = clk_q;
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (NUM_CH=2, CNT_W=8, DEFAULT_DIV=4).
module tb_prog_clock_divider;

  localparam int unsigned NumCh  = 2;
  localparam int unsigned CntW   = 8;
  localparam int unsigned DefDiv = 4;

  logic clkin = 1'b0;
  logic rst;
`ifdef SINGLE_STEP_EN
  logic step_mode;
  logic step_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  prog_clock_divider_if #(.NUM_CH(NumCh), .CNT_W(CntW)) bus ();

  prog_clock_divider #(
    .NUM_CH      (NumCh),
    .CNT_W       (CntW),
    .DEFAULT_DIV (DefDiv)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
`ifdef SINGLE_STEP_EN
    .step_mode (step_mode),
    .step_i    (step_i),
`endif
    .bus       (bus)
  );

  always #5 clkin = ~clkin;

  // One rising edge, then settle before sampling or driving.
  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d1, input logic [7:0] d0, input logic [1:0] mode);
    bus.div_i    = {d1, d0};
    bus.mode_sq  = mode;
    bus.div_load = 2'b11;
    cyc();
    bus.div_load = 2'b00;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.div_load = 2'b00;
    bus.mode_sq = 2'b00;
    bus.div_i = '0;
    cyc();
    cyc();
    n_checks++;
    if (bus.tick_o !== 2'b00) begin
      $display("FAIL reset_tick got %b want 00", bus.tick_o); n_fail++;
    end
    n_checks++;
    if (bus.clkout !== 2'b00) begin
      $display("FAIL reset_clkout got %b want 00", bus.clkout); n_fail++;
    end
    rst = 1'b0;
    bus.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp = (k % 4 == 0) ? 2'b11 : 2'b00;
      n_checks++;
      if (bus.tick_o !== exp) begin
        $display("FAIL reset_run_tick edge=%0d got %b want %b", k, bus.tick_o, exp); n_fail++;
      end
      n_checks++;
      if (bus.clkout !== exp) begin
        $display("FAIL reset_run_pulse edge=%0d got %b want %b", k, bus.clkout, exp); n_fail++;
      end
    end
  endtask

  task automatic test_load();
    logic [1:0] exp_t, exp_c;
    do_load(8'd2, 8'd3, 2'b10);
    n_checks++;
    if (bus.tick_o !== 2'b00 || bus.clkout !== 2'b00) begin
      $display("FAIL load_edge got tick=%b clk=%b want 00/00", bus.tick_o, bus.clkout); n_fail++;
    end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_t = {1'(k % 2 == 0), 1'(k % 3 == 0)};
      exp_c = {1'((k / 2) % 2 == 1), exp_t[0]};
      n_checks++;
      if (bus.tick_o !== exp_t) begin
        $display("FAIL load_tick edge=%0d got %b want %b", k, bus.tick_o, exp_t); n_fail++;
      end
      n_checks++;
      if (bus.clkout !== exp_c) begin
        $display("FAIL load_clkout edge=%0d got %b want %b", k, bus.clkout, exp_c); n_fail++;
      end
    end
  endtask

  task automatic test_div01();
    do_load(8'd1, 8'd0, 2'b00);
    n_checks++;
    if (bus.tick_o !== 2'b00) begin
      $display("FAIL div01_load got %b want 00", bus.tick_o); n_fail++;
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_checks++;
      if (bus.tick_o !== 2'b11) begin
        $display("FAIL div01_tick edge=%0d got %b want 11", k, bus.tick_o); n_fail++;
      end
    end
  endtask

  task automatic test_en_hold();
    logic [1:0] exp;
    do_load(8'd4, 8'd4, 2'b00);
    cyc();
    bus.en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      n_checks++;
      if (bus.tick_o !== 2'b00) begin
        $display("FAIL en_low_tick edge=%0d got %b want 00", k, bus.tick_o); n_fail++;
      end
    end
    bus.en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      exp = (k == 3 || k == 7) ? 2'b11 : 2'b00;
      n_checks++;
      if (bus.tick_o !== exp) begin
        $display("FAIL en_resume_tick edge=%0d got %b want %b", k, bus.tick_o, exp); n_fail++;
      end
    end
  endtask

  task automatic test_load_terminal();
    logic [1:0] exp;
    do_load(8'd4, 8'd4, 2'b00);
    cyc();
    cyc();
    cyc();
    do_load(8'd3, 8'd3, 2'b00);
    n_checks++;
    if (bus.tick_o !== 2'b00) begin
      $display("FAIL load_terminal_lost got %b want 00", bus.tick_o); n_fail++;
    end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      exp = (k == 3) ? 2'b11 : 2'b00;
      n_checks++;
      if (bus.tick_o !== exp) begin
        $display("FAIL load_terminal_tick edge=%0d got %b want %b", k, bus.tick_o, exp); n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    do_load(8'd3, 8'd3, 2'b11);
    cyc();
    cyc();
    cyc();
    n_checks++;
    if (bus.tick_o !== 2'b11 || bus.clkout !== 2'b11) begin
      $display("FAIL sq_first_toggle got tick=%b clk=%b want 11/11", bus.tick_o, bus.clkout);
      n_fail++;
    end
    cyc();
    n_checks++;
    if (bus.clkout !== 2'b11) begin
      $display("FAIL sq_hold got %b want 11", bus.clkout); n_fail++;
    end
    rst = 1'b1;
    cyc();
    n_checks++;
    if (bus.tick_o !== 2'b00 || bus.clkout !== 2'b00) begin
      $display("FAIL rst_mid got tick=%b clk=%b want 00/00", bus.tick_o, bus.clkout); n_fail++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      exp = (k == 4) ? 2'b11 : 2'b00;
      n_checks++;
      if (bus.tick_o !== exp || bus.clkout !== exp) begin
        $display("FAIL rst_release edge=%0d got tick=%b clk=%b want %b", k, bus.tick_o,
                 bus.clkout, exp);
        n_fail++;
      end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    int cnt0, cnt1;
    logic [1:0] exp;
    cnt0 = 0;
    cnt1 = 0;
    do_load(8'd4, 8'd4, 2'b00);
    step_mode = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
        cyc(); cnt0 += int'(bus.tick_o[0]); cnt1 += int'(bus.tick_o[1]);
      end
      step_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cyc(); cnt0 += int'(bus.tick_o[0]); cnt1 += int'(bus.tick_o[1]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(); cnt0 += int'(bus.tick_o[0]); cnt1 += int'(bus.tick_o[1]);
    end
    n_checks++;
    if (cnt0 != 3 || cnt1 != 3) begin
      $display("FAIL step_count got %0d/%0d want 3/3", cnt0, cnt1); n_fail++;
    end
    step_mode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      exp = (k == 4) ? 2'b11 : 2'b00;
      n_checks++;
      if (bus.tick_o !== exp) begin
        $display("FAIL step_frozen_cnt edge=%0d got %b want %b", k, bus.tick_o, exp); n_fail++;
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SINGLE_STEP_EN
    step_mode = 1'b0;
    step_i    = 1'b0;
`endif
    test_reset();
    test_load();
    test_div01();
    test_en_hold();
    test_load_terminal();
    test_reset_mid();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
